// File: rtl/csr_unit.sv
// csr_unit
//   Machine-mode CSR responder sitting beside riscv_core. Decodes the core's
//   CSR read/write strobes, holds the M-mode trap state (mstatus, mie, mip,
//   mtvec, mepc, mcause, mscratch) and the 64-bit mcycle/minstret counters,
//   and gates the PLIC external interrupt into a request for the core.
//
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     csr_rd/_addr/_data   combinational read port (data is 0 when not reading)
//     csr_wr/_addr/_data   write port, final value already resolved by the core
//     instret              one pulse per retired instruction
//     EIP                  external interrupt pending level from the PLIC
//     irq_req              interrupt request to the core (MIE & MEIE & EIP)
//     irq_ack, irq_pc      core takes the interrupt, return address to capture
//     mret                 core executes MRET
//     mtvec_out, mepc_out  trap vector base and MRET return address
//     IRQ_complete         one-cycle pulse to the PLIC after an MRET
module csr_unit #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_rd,
  input  logic [11:0] csr_rd_addr,
  output logic [31:0] csr_rd_data,
  input  logic        csr_wr,
  input  logic [11:0] csr_wr_addr,
  input  logic [31:0] csr_wr_data,
  input  logic        instret,
  input  logic        EIP,
  output logic        irq_req,
  input  logic        irq_ack,
  input  logic [31:0] irq_pc,
  input  logic        mret,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        IRQ_complete
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MCAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] EPC_ALIGN_MASK = 32'hFFFF_FFFC;

  // architectural state
  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic        mie_meie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;
  logic        irq_complete_r;

  // decoded write enables and next-state values
  logic        wr_mstatus_s;
  logic        wr_mie_s;
  logic        wr_mtvec_s;
  logic        wr_mscratch_s;
  logic        wr_mepc_s;
  logic        wr_mcause_s;
  logic        wr_mcycle_s;
  logic        wr_mcycleh_s;
  logic        wr_minstret_s;
  logic        wr_minstreth_s;
  logic        take_trap_s;
  logic        take_ret_s;
  logic [63:0] mcycle_next_s;
  logic [63:0] minstret_next_s;
  logic [31:0] mstatus_view_s;
  logic [31:0] mie_view_s;
  logic [31:0] mip_view_s;
  logic [31:0] rd_data_s;

  // irq_ack wins over a simultaneous mret
  assign take_trap_s = irq_ack;
  assign take_ret_s  = mret & ~irq_ack;

  assign mstatus_view_s = {24'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
  assign mie_view_s     = {20'd0, mie_meie_r, 11'd0};
  assign mip_view_s     = {20'd0, EIP, 11'd0};

  // Write address decode; trap/return sequencing owns mstatus (and mepc/mcause on a trap)
  always_comb begin
    wr_mstatus_s   = 1'b0;
    wr_mie_s       = 1'b0;
    wr_mtvec_s     = 1'b0;
    wr_mscratch_s  = 1'b0;
    wr_mepc_s      = 1'b0;
    wr_mcause_s    = 1'b0;
    wr_mcycle_s    = 1'b0;
    wr_mcycleh_s   = 1'b0;
    wr_minstret_s  = 1'b0;
    wr_minstreth_s = 1'b0;
    if (csr_wr) begin
      case (csr_wr_addr)
        ADDR_MSTATUS:   wr_mstatus_s   = ~take_trap_s & ~take_ret_s;
        ADDR_MIE:       wr_mie_s       = 1'b1;
        ADDR_MTVEC:     wr_mtvec_s     = 1'b1;
        ADDR_MSCRATCH:  wr_mscratch_s  = 1'b1;
        ADDR_MEPC:      wr_mepc_s      = ~take_trap_s;
        ADDR_MCAUSE:    wr_mcause_s    = ~take_trap_s;
        ADDR_MCYCLE:    wr_mcycle_s    = 1'b1;
        ADDR_MCYCLEH:   wr_mcycleh_s   = 1'b1;
        ADDR_MINSTRET:  wr_minstret_s  = 1'b1;
        ADDR_MINSTRETH: wr_minstreth_s = 1'b1;
        default:        wr_mstatus_s   = 1'b0;
      endcase
    end else begin
      wr_mstatus_s = 1'b0;
    end
  end

  // Counter next values: a written half replaces that half and freezes the other for the cycle
  always_comb begin
    mcycle_next_s   = mcycle_r + 64'd1;
    minstret_next_s = minstret_r;
    if (wr_mcycle_s) begin
      mcycle_next_s = {mcycle_r[63:32], csr_wr_data};
    end else if (wr_mcycleh_s) begin
      mcycle_next_s = {csr_wr_data, mcycle_r[31:0]};
    end else begin
      mcycle_next_s = mcycle_r + 64'd1;
    end
    if (wr_minstret_s) begin
      minstret_next_s = {minstret_r[63:32], csr_wr_data};
    end else if (wr_minstreth_s) begin
      minstret_next_s = {csr_wr_data, minstret_r[31:0]};
    end else if (instret) begin
      minstret_next_s = minstret_r + 64'd1;
    end else begin
      minstret_next_s = minstret_r;
    end
  end

  // Read mux; no bypass, so a same-cycle write is not visible until the next cycle
  always_comb begin
    rd_data_s = 32'd0;
    if (csr_rd) begin
      case (csr_rd_addr)
        ADDR_MSTATUS:                 rd_data_s = mstatus_view_s;
        ADDR_MISA:                    rd_data_s = MISA_VAL;
        ADDR_MIE:                     rd_data_s = mie_view_s;
        ADDR_MTVEC:                   rd_data_s = mtvec_r;
        ADDR_MSCRATCH:                rd_data_s = mscratch_r;
        ADDR_MEPC:                    rd_data_s = mepc_r;
        ADDR_MCAUSE:                  rd_data_s = mcause_r;
        ADDR_MIP:                     rd_data_s = mip_view_s;
        ADDR_MCYCLE,   ADDR_CYCLE:    rd_data_s = mcycle_r[31:0];
        ADDR_MCYCLEH,  ADDR_CYCLEH:   rd_data_s = mcycle_r[63:32];
        ADDR_MINSTRET, ADDR_INSTRET:  rd_data_s = minstret_r[31:0];
        ADDR_MINSTRETH, ADDR_INSTRETH: rd_data_s = minstret_r[63:32];
        ADDR_MHARTID:                 rd_data_s = HART_ID;
        default:                      rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // mstatus interrupt-enable stack: trap pushes MIE into MPIE, mret pops it back
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
    end else if (take_trap_s) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (take_ret_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (wr_mstatus_s) begin
      mstatus_mie_r  <= csr_wr_data[3];
      mstatus_mpie_r <= csr_wr_data[7];
    end
  end

  // Trap capture registers mepc/mcause; the trap overrides software writes
  always_ff @(posedge clk) begin
    if (reset) begin
      mepc_r   <= 32'd0;
      mcause_r <= 32'd0;
    end else begin
      if (take_trap_s) begin
        mepc_r   <= irq_pc & EPC_ALIGN_MASK;
        mcause_r <= MCAUSE_MEI;
      end else begin
        if (wr_mepc_s) begin
          mepc_r <= csr_wr_data & EPC_ALIGN_MASK;
        end
        if (wr_mcause_s) begin
          mcause_r <= csr_wr_data;
        end
      end
    end
  end

  // Plain software-owned registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_meie_r <= 1'b0;
      mtvec_r    <= 32'd0;
      mscratch_r <= 32'd0;
    end else begin
      if (wr_mie_s) begin
        mie_meie_r <= csr_wr_data[11];
      end
      if (wr_mtvec_s) begin
        mtvec_r <= csr_wr_data;
      end
      if (wr_mscratch_s) begin
        mscratch_r <= csr_wr_data;
      end
    end
  end

  // 64-bit performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r   <= mcycle_next_s;
      minstret_r <= minstret_next_s;
    end
  end

  // Completion pulse to the PLIC, one cycle after an accepted mret
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_complete_r <= 1'b0;
    end else begin
      irq_complete_r <= take_ret_s;
    end
  end

  assign csr_rd_data  = rd_data_s;
  assign irq_req      = mstatus_mie_r & mie_meie_r & EIP;
  assign mtvec_out    = {mtvec_r[31:2], 2'b00};
  assign mepc_out     = mepc_r;
  assign IRQ_complete = irq_complete_r;

endmodule
